// File: rtl/izh_thr_pkg.sv
// Shared types and constants for the threshold engine.
package izh_thr_pkg;

  typedef enum logic [1:0] {
    OP_TREF = 2'd0,
    OP_EXC  = 2'd1,
    OP_INH  = 2'd2,
    OP_SPK  = 2'd3
  } op_e;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic int thr_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int thr_min();
    return 1;
  endfunction

endpackage

// File: rtl/izh_thr_update.sv
// Combinational next-state for one neuron's threshold modifier and leak counter.
module izh_thr_update
  import izh_thr_pkg::*;
#(
  parameter int THR_W = 4,
  parameter int CNT_W = 4
) (
  input  logic [THR_W-2:0] cfg_thr,
  input  logic             cfg_thrvar_en,
  input  logic             cfg_sel_of,
  input  logic [CNT_W-1:0] cfg_thrleak,
  input  logic             cfg_acc_en,
  input  logic             cfg_burst_incr,
  input  logic [1:0]       op,
  input  logic [2:0]       burst,
  input  logic [THR_W-1:0] stim,
  input  logic [THR_W-1:0] thrmod,
  input  logic [CNT_W-1:0] cnt,
  output logic [THR_W-1:0] thrmod_nxt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic [THR_W-1:0] thr_eff_nxt,
  output logic             clipped
);

  localparam int SW = THR_W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(thr_max(THR_W));
  localparam logic signed [SW-1:0] MIN_S = SW'(thr_min());
  localparam logic signed [SW-1:0] ONE_S = SW'(1);

  logic signed [SW-1:0] thr_s, mod_s, stim_s, inc_s, eff_cur, target, eff_new;
  logic [2:0] inc;
  logic       up_evt, upd;

  function automatic logic signed [SW-1:0] clamp(input logic signed [SW-1:0] v);
    if (v > MAX_S) return MAX_S;
    if (v < MIN_S) return MIN_S;
    return v;
  endfunction

  assign thr_s   = signed'({{(SW-THR_W+1){1'b0}}, cfg_thr});
  assign mod_s   = signed'({{2{thrmod[THR_W-1]}}, thrmod});
  assign stim_s  = signed'({{2{stim[THR_W-1]}}, stim});
  assign inc     = !cfg_burst_incr ? 3'd1 : (burst == 3'd7) ? 3'd7 : burst + 3'd1;
  assign inc_s   = signed'({{(SW-3){1'b0}}, inc});
  assign eff_cur = thr_s + mod_s;
  assign up_evt  = cfg_sel_of ? (op == OP_SPK) : (op == OP_EXC);

  // Every modifying path produces a target thr_eff, then one shared clamp
  // derives the stored modifier and the clip flag.
  always_comb begin
    target      = eff_cur;
    upd         = 1'b0;
    cnt_nxt     = cnt;
    eff_new     = eff_cur;
    thrmod_nxt  = thrmod;
    thr_eff_nxt = THR_W'(eff_cur);
    clipped     = 1'b0;
    if (cfg_acc_en) begin
      if (op == OP_TREF) begin
        target = thr_s + stim_s;
        upd    = 1'b1;
      end
    end else if (cfg_thrvar_en) begin
      if (up_evt) begin
        target = eff_cur + inc_s;
        upd    = 1'b1;
      end else if (op == OP_INH && !cfg_sel_of) begin
        target = eff_cur - ONE_S;
        upd    = 1'b1;
      end else if (op == OP_TREF && cfg_thrleak != '0) begin
        if (cnt == cfg_thrleak - 1'b1) begin
          cnt_nxt = '0;
          if (mod_s != '0) begin
            target = (mod_s > '0) ? eff_cur - ONE_S : eff_cur + ONE_S;
            upd    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end
    if (upd) begin
      eff_new     = clamp(target);
      clipped     = (eff_new != target);
      thrmod_nxt  = THR_W'(eff_new - thr_s);
      thr_eff_nxt = THR_W'(eff_new);
    end
  end

endmodule

// File: rtl/izh_thr_adapt_engine.sv
// Time-multiplexed effective-threshold engine.
// Optional: IZH_THR_STATS_EN adds the sat_cnt clip counter port.
module izh_thr_adapt_engine
  import izh_thr_pkg::*;
#(
  parameter  int N_NEUR = 16,
  parameter  int THR_W  = 4,
  parameter  int CNT_W  = 4,
  localparam int ADDR_W = $clog2(N_NEUR)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [THR_W-2:0]  cfg_thr,
  input  logic              cfg_thrvar_en,
  input  logic              cfg_sel_of,
  input  logic [CNT_W-1:0]  cfg_thrleak,
  input  logic              cfg_acc_en,
  input  logic              cfg_burst_incr,
  input  logic              cfg_clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_op,
  input  logic [2:0]        req_burst,
  input  logic [THR_W-1:0]  req_stim,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [THR_W-1:0]  rsp_thr_eff,
  output logic              busy
`ifdef IZH_THR_STATS_EN
  ,
  output logic [15:0]       sat_cnt
`endif
);

  localparam logic [ADDR_W:0]   N_LIM    = (ADDR_W+1)'(N_NEUR);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEUR - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_idx;
  logic [THR_W-1:0]  thrmod_mem [N_NEUR];
  logic [CNT_W-1:0]  cnt_mem    [N_NEUR];
  logic              in_range, accept, hit;
  logic [ADDR_W-1:0] rd_idx;
  logic [THR_W-1:0]  thrmod_nxt, thr_eff_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              clipped;

  assign in_range  = {1'b0, req_addr} < N_LIM;
  assign req_ready = (state_q == S_RUN) && !cfg_clr;
  assign busy      = (state_q == S_INIT);
  assign accept    = req_valid && req_ready;
  assign hit       = accept && in_range;
  assign rd_idx    = in_range ? req_addr : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (sweep_idx == LAST_IDX) state_d = S_RUN;
      S_RUN:   if (cfg_clr) state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    sweep_idx <= '0;
    else if (state_q == S_INIT) sweep_idx <= (sweep_idx == LAST_IDX) ? '0 : sweep_idx + 1'b1;
    else                        sweep_idx <= '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < N_NEUR; i++) begin
        thrmod_mem[i] <= '0;
        cnt_mem[i]    <= '0;
      end
    end else if (state_q == S_INIT) begin
      thrmod_mem[sweep_idx] <= '0;
      cnt_mem[sweep_idx]    <= '0;
    end else if (hit) begin
      thrmod_mem[rd_idx] <= thrmod_nxt;
      cnt_mem[rd_idx]    <= cnt_nxt;
    end
  end

  izh_thr_update #(
    .THR_W (THR_W),
    .CNT_W (CNT_W)
  ) u_update (
    .cfg_thr        (cfg_thr),
    .cfg_thrvar_en  (cfg_thrvar_en),
    .cfg_sel_of     (cfg_sel_of),
    .cfg_thrleak    (cfg_thrleak),
    .cfg_acc_en     (cfg_acc_en),
    .cfg_burst_incr (cfg_burst_incr),
    .op             (req_op),
    .burst          (req_burst),
    .stim           (req_stim),
    .thrmod         (thrmod_mem[rd_idx]),
    .cnt            (cnt_mem[rd_idx]),
    .thrmod_nxt     (thrmod_nxt),
    .cnt_nxt        (cnt_nxt),
    .thr_eff_nxt    (thr_eff_nxt),
    .clipped        (clipped)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid   <= 1'b0;
      rsp_addr    <= '0;
      rsp_thr_eff <= '0;
    end else begin
      rsp_valid <= hit;
      if (hit) begin
        rsp_addr    <= req_addr;
        rsp_thr_eff <= thr_eff_nxt;
      end
    end
  end

`ifdef IZH_THR_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                 sat_cnt <= '0;
    else if (cfg_clr)                        sat_cnt <= '0;
    else if (hit && clipped && sat_cnt != '1) sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_izh_thr_adapt_engine.sv
module tb_izh_thr_adapt_engine;
  import izh_thr_pkg::*;

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [2:0] thr;
    logic [3:0] flags;  // thrvar, sel_of, acc, burst_incr
    logic [2:0] burst;
    logic [3:0] stim;
    logic [3:0] leak;
    logic [3:0] exp_eff;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] cfg_thr;
  logic       cfg_thrvar_en, cfg_sel_of, cfg_acc_en, cfg_burst_incr, cfg_clr;
  logic [3:0] cfg_thrleak;
  logic       req_valid, req_ready;
  logic [3:0] req_addr;
  logic [1:0] req_op;
  logic [2:0] req_burst;
  logic [3:0] req_stim;
  logic       rsp_valid;
  logic [3:0] rsp_addr, rsp_thr_eff;
  logic       busy;
  logic       v17, rdy17, rsp_valid17, busy17;
  logic [4:0] addr17, rsp_addr17;
  logic [3:0] eff17;
`ifdef IZH_THR_STATS_EN
  logic [15:0] sat_cnt, sat_cnt17, sat0;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  izh_thr_adapt_engine #(.N_NEUR(16), .THR_W(4), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .cfg_thr(cfg_thr), .cfg_thrvar_en(cfg_thrvar_en),
    .cfg_sel_of(cfg_sel_of), .cfg_thrleak(cfg_thrleak), .cfg_acc_en(cfg_acc_en),
    .cfg_burst_incr(cfg_burst_incr), .cfg_clr(cfg_clr), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op), .req_burst(req_burst),
    .req_stim(req_stim), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
    .rsp_thr_eff(rsp_thr_eff), .busy(busy)
`ifdef IZH_THR_STATS_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  izh_thr_adapt_engine #(.N_NEUR(17), .THR_W(4), .CNT_W(4)) dut17 (
    .CLK(CLK), .RST(RST), .cfg_thr(cfg_thr), .cfg_thrvar_en(cfg_thrvar_en),
    .cfg_sel_of(cfg_sel_of), .cfg_thrleak(cfg_thrleak), .cfg_acc_en(cfg_acc_en),
    .cfg_burst_incr(cfg_burst_incr), .cfg_clr(1'b0), .req_valid(v17),
    .req_ready(rdy17), .req_addr(addr17), .req_op(req_op), .req_burst(req_burst),
    .req_stim(req_stim), .rsp_valid(rsp_valid17), .rsp_addr(rsp_addr17),
    .rsp_thr_eff(eff17), .busy(busy17)
`ifdef IZH_THR_STATS_EN
    , .sat_cnt(sat_cnt17)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp_v);
  endtask

  function automatic vec_t mkv(input logic [1:0] op, input logic [3:0] addr, input logic [2:0] thr,
                               input logic [3:0] flags, input logic [2:0] burst,
                               input logic [3:0] stim, input logic [3:0] leak,
                               input logic [3:0] exp_eff);
    vec_t v;
    v.op = op; v.addr = addr; v.thr = thr; v.flags = flags;
    v.burst = burst; v.stim = stim; v.leak = leak; v.exp_eff = exp_eff;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (n < 40 && !req_ready) begin
      @(posedge CLK); #1;
      n++;
    end
    check(name, 32'(n), 32'd16);
  endtask

  task automatic issue(input logic [3:0] addr, input logic [1:0] op);
    req_valid = 1'b1; req_addr = addr; req_op = op;
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; cfg_thr = 3'd3; cfg_thrvar_en = 0; cfg_sel_of = 0; cfg_acc_en = 0;
    cfg_burst_incr = 0; cfg_clr = 0; cfg_thrleak = 4'd0;
    req_valid = 0; req_addr = 4'd0; req_op = OP_TREF; req_burst = 3'd0; req_stim = 4'd0;
    v17 = 0; addr17 = 5'd0;

    for (int a = 0; a < 16; a++) tbl.push_back(mkv(OP_TREF, 4'(a), 3'd3, 4'b0000, 3'd0, 4'd0, 4'd0, 4'd3));
    tbl.push_back(mkv(OP_EXC, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd4));
    tbl.push_back(mkv(OP_EXC, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd5));
    tbl.push_back(mkv(OP_EXC, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd6));
    tbl.push_back(mkv(OP_EXC, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd7));
    tbl.push_back(mkv(OP_EXC, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd7));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd6));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd5));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd4));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd3));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd2));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd1));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd1));
    tbl.push_back(mkv(OP_INH, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd1));
    tbl.push_back(mkv(OP_SPK, 4'd3, 3'd3, 4'b1101, 3'd2, 4'd0, 4'd0, 4'd6));
    tbl.push_back(mkv(OP_SPK, 4'd3, 3'd3, 4'b1101, 3'd2, 4'd0, 4'd0, 4'd7));
    tbl.push_back(mkv(OP_EXC, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd4));
    tbl.push_back(mkv(OP_EXC, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd5));
    tbl.push_back(mkv(OP_TREF, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd3, 4'd5));
    tbl.push_back(mkv(OP_TREF, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd3, 4'd5));
    tbl.push_back(mkv(OP_TREF, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd3, 4'd4));
    tbl.push_back(mkv(OP_TREF, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd3, 4'd4));
    tbl.push_back(mkv(OP_TREF, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd3, 4'd4));
    tbl.push_back(mkv(OP_TREF, 4'd5, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd3, 4'd3));
    tbl.push_back(mkv(OP_TREF, 4'd7, 3'd3, 4'b0010, 3'd0, 4'd6, 4'd0, 4'd7));
    tbl.push_back(mkv(OP_TREF, 4'd7, 3'd3, 4'b0010, 3'd0, 4'hB, 4'd0, 4'd1));
    tbl.push_back(mkv(OP_TREF, 4'd7, 3'd3, 4'b0010, 3'd0, 4'd2, 4'd0, 4'd5));
    tbl.push_back(mkv(OP_EXC, 4'd7, 3'd3, 4'b0010, 3'd0, 4'd0, 4'd0, 4'd5));
    tbl.push_back(mkv(OP_SPK, 4'd2, 3'd3, 4'b1101, 3'd2, 4'd0, 4'd0, 4'd4));
    tbl.push_back(mkv(OP_SPK, 4'd2, 3'd3, 4'b1101, 3'd2, 4'd0, 4'd0, 4'd7));
    tbl.push_back(mkv(OP_EXC, 4'd2, 3'd3, 4'b0000, 3'd0, 4'd0, 4'd0, 4'd7));
    tbl.push_back(mkv(OP_TREF, 4'd2, 3'd3, 4'b1000, 3'd0, 4'd0, 4'd0, 4'd7));
    tbl.push_back(mkv(OP_TREF, 4'd7, 3'd5, 4'b0000, 3'd0, 4'd0, 4'd0, 4'd7));

    #2;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_rsp", 32'({rsp_valid, rsp_addr, rsp_thr_eff}), 32'd0);
    #21;
    RST = 1'b0;
    wait_ready("reset_ready_latency");
    check("run_busy", 32'(busy), 32'd0);

    foreach (tbl[i]) begin
      cfg_thr = tbl[i].thr;
      {cfg_thrvar_en, cfg_sel_of, cfg_acc_en, cfg_burst_incr} = tbl[i].flags;
      cfg_thrleak = tbl[i].leak;
      req_valid = 1'b1; req_addr = tbl[i].addr; req_op = tbl[i].op;
      req_burst = tbl[i].burst; req_stim = tbl[i].stim;
`ifdef IZH_THR_STATS_EN
      if (i == 29) sat0 = sat_cnt;
`endif
      @(posedge CLK); #1;
      check($sformatf("vec%0d", i), 32'({rsp_valid, rsp_addr, rsp_thr_eff}),
            32'({1'b1, tbl[i].addr, tbl[i].exp_eff}));
`ifdef IZH_THR_STATS_EN
      if (i == 30) check("sat_cnt_burst_clip", 32'(sat_cnt), 32'(sat0 + 16'd1));
`endif
    end
    req_valid = 1'b0;

    cfg_thr = 3'd3; cfg_thrvar_en = 0; cfg_sel_of = 0; cfg_acc_en = 0;
    cfg_burst_incr = 0; cfg_thrleak = 4'd0;
    req_valid = 1'b1; req_addr = 4'd2; req_op = OP_TREF;
    cfg_clr = 1'b1;
    #1;
    check("clr_ready_low", 32'(req_ready), 32'd0);
    @(posedge CLK); #1;
    cfg_clr = 1'b0; req_valid = 1'b0;
    check("clr_no_accept", 32'(rsp_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
`ifdef IZH_THR_STATS_EN
    check("clr_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    wait_ready("clr_sweep_latency");
    issue(4'd2, OP_TREF);
    check("clr_addr2", 32'({rsp_valid, rsp_addr, rsp_thr_eff}), 32'({1'b1, 4'd2, 4'd3}));
    issue(4'd7, OP_TREF);
    check("clr_addr7", 32'({rsp_valid, rsp_addr, rsp_thr_eff}), 32'({1'b1, 4'd7, 4'd3}));

    check("n17_ready", 32'(rdy17), 32'd1);
    v17 = 1'b1; addr17 = 5'd17; req_op = OP_TREF;
    @(posedge CLK); #1;
    check("n17_addr17_dropped", 32'(rsp_valid17), 32'd0);
    addr17 = 5'd16;
    @(posedge CLK); #1;
    check("n17_addr16", 32'({rsp_valid17, rsp_addr17, eff17}), 32'({1'b1, 5'd16, 4'd3}));
    addr17 = 5'd31;
    @(posedge CLK); #1;
    check("n17_addr31_dropped", 32'(rsp_valid17), 32'd0);
    v17 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
